// File: rtl/add_stream_sequencer_if.sv
// Handshake and adder-side bus for add_stream_sequencer: operand input stream,
// adder drive/return, result output stream and the sticky error flag.
interface add_stream_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] in_a;
  logic [0:WIDTH-1] in_b;
  logic             in_ci;
  logic             in_split;
  logic             in_first;
  logic             in_last;

  logic [0:WIDTH-1] add_a;
  logic [0:WIDTH-1] add_b;
  logic             add_ci;
  logic             add_split;
  logic [0:WIDTH-1] add_s;
  logic             add_co;

  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] out_s;
  logic             out_co;
  logic             out_last;
  logic             proto_err;

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_split, in_first, in_last,
    output in_ready,
    output add_a, add_b, add_ci, add_split,
    input  add_s, add_co,
    output out_valid, out_s, out_co, out_last, proto_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_ci, in_split, in_first, in_last,
    input  in_ready,
    input  add_a, add_b, add_ci, add_split,
    output add_s, add_co,
    input  out_valid, out_s, out_co, out_last, proto_err,
    output out_ready
  );
endinterface

// File: rtl/add_stream_sequencer.sv
// Operand sequencer and result collector around a 16-bit split-capable adder:
// one operand stage, carry chaining across packet words, and a small result FIFO.
module add_stream_sequencer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  add_stream_sequencer_if.slave io
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } state_t;

  typedef struct packed {
    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] b;
    logic             ci;
    logic             first;
    logic             last;
  } s1_t;

  typedef struct packed {
    logic [0:WIDTH-1] s;
    logic             co;
    logic             last;
  } res_t;

  state_t            state_q, state_d;
  s1_t               s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;
  logic              carry_q, carry_d;
  logic              mode_q, mode_d;
  logic              perr_q, perr_d;
  res_t              fifo_q [DEPTH];
  res_t              fifo_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic out_valid_c;
  logic pop_c;
  logic s1_move_c;
  logic in_ready_c;
  logic accept_c;
  logic eff_first_c;
  logic frame_err_c;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: s1 drains into the FIFO whenever there is room, including room
  // freed by a pop in the same cycle.
  always_comb begin
    out_valid_c = (count_q != '0);
    pop_c       = out_valid_c && io.out_ready;
    s1_move_c   = s1_valid_q && ((count_q < CNT_W'(DEPTH)) || pop_c);
    in_ready_c  = !s1_valid_q || s1_move_c;
    accept_c    = io.in_valid && in_ready_c;
    eff_first_c = io.in_first || (state_q == ST_IDLE);
    frame_err_c = ((state_q == ST_IDLE) && !io.in_first) ||
                  ((state_q == ST_IN_PKT) && io.in_first);
  end

  // Next-state for framing FSM, operand stage, carry/mode and FIFO.
  always_comb begin
    state_d    = state_q;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    carry_d    = carry_q;
    mode_d     = mode_q;
    perr_d     = perr_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(s1_move_c) - CNT_W'(pop_c);

    if (s1_move_c) begin
      fifo_d[wr_ptr_q] = '{s: io.add_s, co: io.add_co, last: s1_q.last};
      wr_ptr_d         = next_ptr(wr_ptr_q);
      carry_d          = io.add_co;
      s1_valid_d       = 1'b0;
    end

    if (pop_c) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_d       = '{a: io.in_a, b: io.in_b, ci: io.in_ci,
                     first: eff_first_c, last: io.in_last};
      if (eff_first_c) begin
        mode_d = io.in_split;
      end
      if (frame_err_c) begin
        perr_d = 1'b1;
      end
      state_d = io.in_last ? ST_IDLE : ST_IN_PKT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      carry_q    <= 1'b0;
      mode_q     <= 1'b0;
      perr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      carry_q    <= carry_d;
      mode_q     <= mode_d;
      perr_q     <= perr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

  // Adder drive: first word takes the packet carry-in, later words chain only in 16-bit mode.
  assign io.add_a     = s1_q.a;
  assign io.add_b     = s1_q.b;
  assign io.add_split = mode_q;
  assign io.add_ci    = s1_q.first ? s1_q.ci : (mode_q & carry_q);

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;
  assign io.out_s     = out_valid_c ? fifo_q[rd_ptr_q].s    : '0;
  assign io.out_co    = out_valid_c ? fifo_q[rd_ptr_q].co   : 1'b0;
  assign io.out_last  = out_valid_c ? fifo_q[rd_ptr_q].last : 1'b0;
  assign io.proto_err = perr_q;

endmodule

// File: tb/tb_add_stream_sequencer.sv
// Bench for add_stream_sequencer: behavioural adder, packet-level scoreboard,
// directed vector table, multi-cycle corner sequences and random traffic.
module tb_add_stream_sequencer;

  logic clk;
  logic rst;

  add_stream_sequencer_if #(.WIDTH(16)) bus ();

  add_stream_sequencer #(.DEPTH(2), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference add: chain=1 is one 16-bit add; chain=0 is two bytes with no
  // carry between them, carry-out taken from the upper byte.
  function automatic logic [16:0] lane_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic ci, input logic chain);
    logic [16:0] full;
    logic [8:0]  lo;
    logic [8:0]  hi;
    full = 17'(a) + 17'(b) + 17'(ci);
    lo   = 9'(a[7:0]) + 9'(b[7:0]) + 9'(ci);
    hi   = 9'(a[15:8]) + 9'(b[15:8]);
    return chain ? full : {hi[8], hi[7:0], lo[7:0]};
  endfunction

  logic [16:0] add_r;
  always_comb add_r = lane_add(bus.add_a, bus.add_b, bus.add_ci, bus.add_split);
  assign bus.add_s  = add_r[15:0];
  assign bus.add_co = add_r[16];

  // Packet-level scoreboard, advanced on the handshakes seen before each rising edge.
  logic [17:0] exp_q [$];
  logic        m_in_pkt, m_mode, m_carry, m_perr;

  always @(negedge clk) begin
    logic        ef;
    logic        cin;
    logic [16:0] r;
    logic [17:0] e;
    if (rst) begin
      exp_q.delete();
      m_in_pkt = 1'b0;
      m_mode   = 1'b0;
      m_carry  = 1'b0;
      m_perr   = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_pop: got %h with no result outstanding",
                   {bus.out_s, bus.out_co, bus.out_last});
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 32'({bus.out_s, bus.out_co, bus.out_last}), 32'(e));
        end
        check("sb_proto_err", 32'(bus.proto_err), 32'(m_perr));
      end
      if (bus.in_valid && bus.in_ready) begin
        ef = bus.in_first || !m_in_pkt;
        if (bus.in_first == m_in_pkt) m_perr = 1'b1;
        if (ef) begin
          m_mode = bus.in_split;
          cin    = bus.in_ci;
        end else begin
          cin = m_mode & m_carry;
        end
        r        = lane_add(bus.in_a, bus.in_b, cin, m_mode);
        m_carry  = r[16];
        m_in_pkt = !bus.in_last;
        exp_q.push_back({r[15:0], r[16], bus.in_last});
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic sp, input logic f, input logic l, output int waited);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_ci    = ci;
    bus.in_split = sp;
    bus.in_first = f;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    waited       = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        ci, sp, f, l;
    logic [15:0] es;
    logic        eco, elast, eaci, easp, eperr;
  } vec_t;

  vec_t vt [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int acc_n;
    int idx;
    int pops0;
    int sent;
    int rem;
    int cyc;
    logic acc;
    logic hold;
    logic [15:0] wa [4];
    logic [15:0] wb [4];
    logic        wf [4];
    logic        wl [4];

    vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{16'h80FF, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{16'h80FF, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[7] = '{16'h1234, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1235, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_ci = 1'b0;
    bus.in_split = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_fields", 32'({bus.out_s, bus.out_co, bus.out_last}), 32'd0);
    check("rst_add_drive", 32'({bus.add_a, bus.add_b, bus.add_ci, bus.add_split}), 32'd0);
    check("rst_proto_err", 32'(bus.proto_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, one word at a time: drive, latency, result, error flag.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].a, vt[i].b, vt[i].ci, vt[i].sp, vt[i].f, vt[i].l, w);
      check($sformatf("vec%0d_add_drive", i),
            32'({bus.add_a, bus.add_b, bus.add_ci, bus.add_split}),
            32'({vt[i].a, vt[i].b, vt[i].eaci, vt[i].easp}));
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_result", i), 32'({bus.out_s, bus.out_co, bus.out_last}),
            32'({vt[i].es, vt[i].eco, vt[i].elast}));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d_proto_err", i), 32'(bus.proto_err), 32'(vt[i].eperr));
    end

    // Back-to-back chained packet with out_ready high: no input stalls expected.
    bus.out_ready = 1'b1;
    acc_n = 0;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, w); acc_n += w;
    send(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, w); acc_n += w;
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, w); acc_n += w;
    check("stream_stalls", 32'(acc_n), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: four chained words into a full pipeline, then release.
    wa = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001};
    wb = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    wf = '{1'b1, 1'b0, 1'b0, 1'b0};
    wl = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus.out_ready = 1'b0;
    pops0 = pops;
    idx = 0; acc_n = 0;
    bus.in_a = wa[0]; bus.in_b = wb[0]; bus.in_ci = 1'b0; bus.in_split = 1'b1;
    bus.in_first = wf[0]; bus.in_last = wl[0]; bus.in_valid = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (c == 6) begin
        check("bp_accepted", 32'(acc_n), 32'd3);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
      end
      @(negedge clk); acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_n++; idx++;
        if (idx < 4) begin
          bus.in_a = wa[idx]; bus.in_b = wb[idx];
          bus.in_first = wf[idx]; bus.in_last = wl[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("bp_total_pops", 32'(pops - pops0), 32'd4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with two words in flight.
    bus.out_ready = 1'b0;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, w);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, w);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_add_ci",    32'(bus.add_ci),    32'd0);
    check("arst_proto_err", 32'(bus.proto_err), 32'd0);
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, w);
    @(posedge clk); #1;
    check("post_rst_result", 32'({bus.out_valid, bus.out_s, bus.out_co, bus.out_last}),
          32'({1'b1, 16'h0002, 1'b0, 1'b1}));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Random traffic with occasional framing errors and random backpressure.
    sent = 0; rem = 0; cyc = 0; hold = 1'b0;
    while (sent < 400 && cyc < 5000) begin
      if (!hold && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: bus.in_a = 16'hFFFF;
          1: bus.in_a = 16'h80FF;
          default: bus.in_a = 16'($urandom);
        endcase
        bus.in_b  = ($urandom_range(0, 2) == 0) ? 16'h0001 : 16'($urandom);
        bus.in_ci = 1'($urandom);
        if (rem == 0) begin
          rem = $urandom_range(1, 4);
          bus.in_first = 1'b1;
          bus.in_split = 1'($urandom);
        end else begin
          bus.in_first = 1'b0;
          bus.in_split = 1'($urandom);
        end
        if ($urandom_range(0, 19) == 0) bus.in_first = ~bus.in_first;
        bus.in_last  = (rem == 1);
        rem--;
        bus.in_valid = 1'b1;
        hold = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk); acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        hold = 1'b0;
        bus.in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    check("rand_sent", 32'(sent), 32'd400);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_out_valid", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
